// File: rtl/ed25519_sign_ctrl.sv
// Host-facing controller for an Ed25519 signing core: buffers the three hashes,
// sequences ready/enable/done handshakes with a timeout, and captures the signature.
module ed25519_sign_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic         ICLK,
  input  logic         IRST,
  input  logic         IWE,
  input  logic         IRE,
  input  logic [5:0]   IADDR,
  input  logic [31:0]  IWDATA,
  input  logic         ISTART,
  output logic [31:0]  ORDATA,
  output logic         OBUSY,
  output logic         OVALID,
  output logic         OERR,
  output logic         OEN,
  input  logic         IREADY,
  input  logic         IDONE,
  output logic [250:0] OHASHD_KEY,
  output logic [511:0] OHASHD_RAM,
  output logic [511:0] OHASHD_SM,
  input  logic [252:0] ISIGN
);

  localparam int unsigned CNT_W = 20;
  localparam int unsigned BUF_W = 512;
  localparam int unsigned SIG_W = 256;
  localparam int unsigned KEY_W = 251;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_READY,
    S_ISSUE,
    S_WAIT_DONE,
    S_DONE,
    S_ERR
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_busy;
  logic               r_valid;
  logic               r_err;
  logic               r_en;
  logic               w_busy_nxt;
  logic               w_valid_nxt;
  logic               w_err_nxt;
  logic               w_en_nxt;
  logic               w_capture;
  logic [BUF_W-1:0]   r_key;
  logic [BUF_W-1:0]   r_ram;
  logic [BUF_W-1:0]   r_sm;
  logic [SIG_W-1:0]   r_sig;
  logic [31:0]        r_rdata;
  logic [31:0]        w_rdata;
  logic               w_wr;
  logic [8:0]         w_bidx;
  logic [7:0]         w_sidx;

  // Key hash is byte-reversed, then three reserved bit groups are dropped.
  function automatic logic [KEY_W-1:0] pack_key(input logic [BUF_W-1:0] k);
    int unsigned ks_i;
    int unsigned k_i;
    pack_key = '0;
    for (int unsigned j = 0; j < KEY_W; j++) begin
      if (j >= 246)    ks_i = j + 261;
      else if (j >= 6) ks_i = j + 258;
      else             ks_i = j + 256;
      k_i = 8 * (63 - ks_i / 8) + ks_i % 8;
      pack_key[8'(j)] = k[9'(k_i)];
    end
  endfunction

  always_ff @(posedge ICLK or posedge IRST) begin
    if (IRST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = r_valid;
    w_err_nxt   = r_err;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (ISTART) begin
          w_state_nxt = S_WAIT_READY;
          w_valid_nxt = 1'b0;
          w_err_nxt   = 1'b0;
        end
      end
      S_WAIT_READY: begin
        if (IREADY) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT_DONE;
        w_cnt_nxt   = '0;
      end
      S_WAIT_DONE: begin
        // Done takes priority over a timeout landing on the same cycle.
        if (IDONE) begin
          w_state_nxt = S_DONE;
          w_valid_nxt = 1'b1;
          w_capture   = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_ERR;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == S_WAIT_READY) || (w_state_nxt == S_ISSUE) ||
                 (w_state_nxt == S_WAIT_DONE);
    w_en_nxt   = (w_state_nxt == S_ISSUE);
  end

  assign w_wr   = IWE & ~r_busy;
  assign w_bidx = {IADDR[3:0], 5'b0};
  assign w_sidx = {IADDR[2:0], 5'b0};

  always_comb begin
    w_rdata = '0;
    case (IADDR[5:4])
      2'd0: w_rdata = r_key[w_bidx +: 32];
      2'd1: w_rdata = r_ram[w_bidx +: 32];
      2'd2: w_rdata = r_sm[w_bidx +: 32];
      default: begin
        if (!IADDR[3])             w_rdata = r_sig[w_sidx +: 32];
        else if (IADDR[2:0] == '0) w_rdata = {29'b0, r_err, r_valid, r_busy};
      end
    endcase
  end

  always_ff @(posedge ICLK or posedge IRST) begin
    if (IRST) begin
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_en    <= 1'b0;
      r_key   <= '0;
      r_ram   <= '0;
      r_sm    <= '0;
      r_sig   <= '0;
      r_rdata <= '0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
      r_en    <= w_en_nxt;
      if (w_wr) begin
        case (IADDR[5:4])
          2'd0:    r_key[w_bidx +: 32] <= IWDATA;
          2'd1:    r_ram[w_bidx +: 32] <= IWDATA;
          2'd2:    r_sm[w_bidx +: 32]  <= IWDATA;
          default: ;
        endcase
      end
      // Three zero bits are re-inserted where the core's packed form omits them.
      if (w_capture) r_sig <= {ISIGN[252:5], 3'b000, ISIGN[4:0]};
      if (IRE)       r_rdata <= w_rdata;
    end
  end

  assign ORDATA     = r_rdata;
  assign OBUSY      = r_busy;
  assign OVALID     = r_valid;
  assign OERR       = r_err;
  assign OEN        = r_en;
  assign OHASHD_KEY = pack_key(r_key);
  assign OHASHD_RAM = r_ram;
  assign OHASHD_SM  = r_sm;

endmodule

// File: tb/tb_ed25519_sign_ctrl.sv
// Randomized bench for ed25519_sign_ctrl against a word/byte-level reference model.
module tb_ed25519_sign_ctrl;

  localparam int unsigned TO = 8;

  logic         ICLK = 1'b0;
  logic         IRST;
  logic         IWE;
  logic         IRE;
  logic [5:0]   IADDR;
  logic [31:0]  IWDATA;
  logic         ISTART;
  logic [31:0]  ORDATA;
  logic         OBUSY;
  logic         OVALID;
  logic         OERR;
  logic         OEN;
  logic         IREADY;
  logic         IDONE;
  logic [250:0] OHASHD_KEY;
  logic [511:0] OHASHD_RAM;
  logic [511:0] OHASHD_SM;
  logic [252:0] ISIGN;

  ed25519_sign_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .ICLK(ICLK), .IRST(IRST), .IWE(IWE), .IRE(IRE), .IADDR(IADDR), .IWDATA(IWDATA),
    .ISTART(ISTART), .ORDATA(ORDATA), .OBUSY(OBUSY), .OVALID(OVALID), .OERR(OERR),
    .OEN(OEN), .IREADY(IREADY), .IDONE(IDONE), .OHASHD_KEY(OHASHD_KEY),
    .OHASHD_RAM(OHASHD_RAM), .OHASHD_SM(OHASHD_SM), .ISIGN(ISIGN)
  );

  always #5 ICLK = ~ICLK;

  int tests_run = 0;
  int fails = 0;
  logic [31:0] mk[16];
  logic [31:0] mr[16];
  logic [31:0] mm[16];
  logic [31:0] ms[8];

  function automatic logic [511:0] model_vec(input int sel);
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < 16; i++)
      v[9'(32*i) +: 32] = (sel == 1) ? mr[i] : (sel == 2) ? mm[i] : mk[i];
    return v;
  endfunction

  function automatic logic [250:0] model_key();
    logic [7:0]   kb[64];
    logic [511:0] ks;
    for (int i = 0; i < 64; i++) kb[i] = 8'(mk[i/4] >> (8 * (i % 4)));
    for (int i = 0; i < 64; i++) ks[9'(8*i) +: 8] = kb[63-i];
    return {ks[511:507], ks[503:264], ks[261:256]};
  endfunction

  function automatic logic [252:0] rnd_sign();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[8'(32*i) +: 32] = $urandom();
    return t[252:0];
  endfunction

  task automatic set_sig_model(input logic [252:0] sg);
    logic [255:0] s;
    s = ((256'(sg) >> 5) << 8) | (256'(sg) & 256'd31);
    for (int j = 0; j < 8; j++) ms[j] = s[8'(32*j) +: 32];
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin mk[i] = '0; mr[i] = '0; mm[i] = '0; end
    for (int i = 0; i < 8; i++) ms[i] = '0;
  endtask

  task automatic tick();
    @(posedge ICLK);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    IWE = 1'b1; IADDR = a; IWDATA = d;
    tick();
    IWE = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    IRE = 1'b1; IADDR = a;
    tick();
    IRE = 1'b0;
    d = ORDATA;
  endtask

  task automatic start_job();
    ISTART = 1'b1;
    tick();
    ISTART = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    IRST = 1'b1;
    tick(); tick();
    tests_run++;
    if ({OBUSY, OVALID, OERR, OEN} !== 4'b0 || ORDATA !== 32'h0) begin
      fails++; $display("FAIL reset_outputs got %b/%h exp 0000/0", {OBUSY, OVALID, OERR, OEN}, ORDATA);
    end
    IRST = 1'b0;
    tick();
    rd(6'h38, d);
    tests_run++;
    if (d !== 32'h0) begin fails++; $display("FAIL reset_status got %h exp 0", d); end
    rd(6'h05, d);
    tests_run++;
    if (d !== 32'h0) begin fails++; $display("FAIL reset_key got %h exp 0", d); end
    tests_run++;
    if (OHASHD_RAM !== '0 || OHASHD_KEY !== '0) begin fails++; $display("FAIL reset_hash nonzero"); end
  endtask

  task automatic test_hash_load();
    logic [31:0] d;
    int k;
    for (int i = 0; i < 16; i++) begin
      mk[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      wr(6'(i), mk[i]);
    end
    tests_run++;
    if (OHASHD_KEY[250:246] !== 5'b00000) begin
      fails++; $display("FAIL key_top5 got %b exp 00000", OHASHD_KEY[250:246]);
    end
    tests_run++;
    if (OHASHD_KEY !== model_key()) begin
      fails++; $display("FAIL key_pack_ramp got %h exp %h", OHASHD_KEY, model_key());
    end
    for (int i = 0; i < 16; i++) begin
      mk[i] = $urandom(); wr(6'(i), mk[i]);
      mr[i] = $urandom(); wr(6'(16+i), mr[i]);
      mm[i] = $urandom(); wr(6'(32+i), mm[i]);
    end
    tests_run++;
    if (OHASHD_KEY !== model_key()) begin
      fails++; $display("FAIL key_pack_rand got %h exp %h", OHASHD_KEY, model_key());
    end
    tests_run++;
    if (OHASHD_RAM !== model_vec(1) || OHASHD_SM !== model_vec(2)) begin
      fails++; $display("FAIL ram_sm_hash got %h exp %h", OHASHD_RAM[63:0], mr[1]);
    end
    for (int n = 0; n < 3; n++) begin
      k = $urandom_range(15);
      rd(6'(k), d);
      tests_run++;
      if (d !== mk[k]) begin fails++; $display("FAIL read_key[%0d] got %h exp %h", k, d, mk[k]); end
      rd(6'(16+k), d);
      tests_run++;
      if (d !== mr[k]) begin fails++; $display("FAIL read_ram[%0d] got %h exp %h", k, d, mr[k]); end
      rd(6'(32+k), d);
      tests_run++;
      if (d !== mm[k]) begin fails++; $display("FAIL read_sm[%0d] got %h exp %h", k, d, mm[k]); end
    end
    rd(6'h3A, d);
    tests_run++;
    if (d !== 32'h0) begin fails++; $display("FAIL read_3a got %h exp 0", d); end
  endtask

  task automatic test_sign_flow();
    logic [31:0] d;
    logic [31:0] w;
    IREADY = 1'b1;
    w = $urandom();
    IWE = 1'b1; ISTART = 1'b1; IADDR = 6'h03; IWDATA = w;
    tick();
    IWE = 1'b0; ISTART = 1'b0;
    mk[3] = w;
    tests_run++;
    if (OBUSY !== 1'b1 || OEN !== 1'b0) begin
      fails++; $display("FAIL start_cycle1 busy/en got %b%b exp 10", OBUSY, OEN);
    end
    tick();
    tests_run++;
    if (OEN !== 1'b1) begin fails++; $display("FAIL oen_latency got %b exp 1", OEN); end
    tests_run++;
    if (OHASHD_KEY !== model_key()) begin
      fails++; $display("FAIL write_with_start got %h exp %h", OHASHD_KEY, model_key());
    end
    tick();
    tests_run++;
    if (OEN !== 1'b0 || OBUSY !== 1'b1) begin
      fails++; $display("FAIL oen_single busy/en got %b%b exp 10", OBUSY, OEN);
    end
    ISIGN = '1; IDONE = 1'b1;
    tick();
    IDONE = 1'b0;
    set_sig_model(ISIGN);
    tests_run++;
    if (ms[0] !== 32'hFFFFFF1F) begin fails++; $display("FAIL model_sig0 got %h exp ffffff1f", ms[0]); end
    for (int j = 0; j < 8; j++) begin
      rd(6'(48+j), d);
      tests_run++;
      if (d !== ms[j]) begin fails++; $display("FAIL sig_ones[%0d] got %h exp %h", j, d, ms[j]); end
    end
    rd(6'h38, d);
    tests_run++;
    if (d !== 32'h2) begin fails++; $display("FAIL status_done got %h exp 2", d); end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    int n;
    IREADY = 1'b1; IDONE = 1'b0; ISIGN = rnd_sign();
    start_job();
    tick(); tick();
    n = 0;
    while (!OERR && n < 50) begin tick(); n++; end
    tests_run++;
    if (n !== int'(TO)) begin fails++; $display("FAIL timeout_cycles got %0d exp %0d", n, TO); end
    rd(6'h38, d);
    tests_run++;
    if (d !== 32'h4) begin fails++; $display("FAIL status_err got %h exp 4", d); end
    rd(6'h30, d);
    tests_run++;
    if (d !== ms[0]) begin fails++; $display("FAIL sig_kept_on_err got %h exp %h", d, ms[0]); end
  endtask

  task automatic test_coincident();
    logic [31:0] d;
    int k;
    IREADY = 1'b1; IDONE = 1'b0;
    start_job();
    tests_run++;
    if (OERR !== 1'b0) begin fails++; $display("FAIL err_clear_on_start got %b exp 0", OERR); end
    tick(); tick();
    repeat (TO - 1) tick();
    tests_run++;
    if (OBUSY !== 1'b1 || OERR !== 1'b0) begin
      fails++; $display("FAIL pre_terminal busy/err got %b%b exp 10", OBUSY, OERR);
    end
    ISIGN = rnd_sign(); IDONE = 1'b1;
    tick();
    IDONE = 1'b0;
    set_sig_model(ISIGN);
    rd(6'h38, d);
    tests_run++;
    if (d !== 32'h2) begin fails++; $display("FAIL coincident_status got %h exp 2", d); end
    k = $urandom_range(7);
    rd(6'(48+k), d);
    tests_run++;
    if (d !== ms[k]) begin fails++; $display("FAIL coincident_sig[%0d] got %h exp %h", k, d, ms[k]); end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] d;
    logic [252:0] good;
    int pulses;
    bit given;
    IREADY = 1'b0; IDONE = 1'b0;
    start_job();
    wr(6'h10, ~mr[0]);
    start_job();
    ISIGN = rnd_sign(); IDONE = 1'b1;
    tick();
    IDONE = 1'b0;
    tests_run++;
    if (OVALID !== 1'b0 || OBUSY !== 1'b1) begin
      fails++; $display("FAIL early_done valid/busy got %b%b exp 01", OVALID, OBUSY);
    end
    IREADY = 1'b1;
    pulses = 0; given = 0; good = '0;
    for (int i = 0; i < 30; i++) begin
      tick();
      IDONE = 1'b0;
      if (OEN) pulses++;
      else if (pulses == 1 && !given) begin
        good = rnd_sign(); ISIGN = good; IDONE = 1'b1; given = 1;
        set_sig_model(good);
      end
    end
    IDONE = 1'b0;
    tests_run++;
    if (pulses !== 1) begin fails++; $display("FAIL oen_pulses got %0d exp 1", pulses); end
    tests_run++;
    if (OHASHD_RAM !== model_vec(1)) begin fails++; $display("FAIL ram_busy_write got %h exp %h", OHASHD_RAM[31:0], mr[0]); end
    rd(6'h10, d);
    tests_run++;
    if (d !== mr[0]) begin fails++; $display("FAIL read_ram0 got %h exp %h", d, mr[0]); end
    ISIGN = ~good; IDONE = 1'b1;
    tick();
    IDONE = 1'b0;
    rd(6'h37, d);
    tests_run++;
    if (d !== ms[7]) begin fails++; $display("FAIL done_outside_wait got %h exp %h", d, ms[7]); end
    tests_run++;
    if (OVALID !== 1'b1) begin fails++; $display("FAIL valid_after_done got %b exp 1", OVALID); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int pulses;
    IREADY = 1'b1; IDONE = 1'b0;
    start_job();
    tick(); tick();
    IRST = 1'b1;
    #1;
    tests_run++;
    if ({OBUSY, OVALID, OERR, OEN} !== 4'b0 || ORDATA !== 32'h0 || OHASHD_SM !== '0) begin
      fails++; $display("FAIL async_reset got %b/%h exp 0000/0", {OBUSY, OVALID, OERR, OEN}, ORDATA);
    end
    tick();
    IRST = 1'b0;
    clear_model();
    ISIGN = '1; IDONE = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (OEN) pulses++; end
    IDONE = 1'b0;
    tests_run++;
    if (pulses !== 0 || OVALID !== 1'b0) begin
      fails++; $display("FAIL post_reset pulses/valid got %0d/%b exp 0/0", pulses, OVALID);
    end
    rd(6'h38, d);
    tests_run++;
    if (d !== 32'h0) begin fails++; $display("FAIL post_reset_status got %h exp 0", d); end
    rd(6'h30, d);
    tests_run++;
    if (d !== ms[0]) begin fails++; $display("FAIL post_reset_sig got %h exp %h", d, ms[0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int n;
    int k;
    logic [252:0] sg;
    for (int it = 0; it < 4; it++) begin
      k = $urandom_range(15);
      mk[k] = $urandom(); wr(6'(k), mk[k]);
      mr[k] = $urandom(); wr(6'(16+k), mr[k]);
      mm[k] = $urandom(); wr(6'(32+k), mm[k]);
      IREADY = 1'b0;
      start_job();
      repeat ($urandom_range(3)) tick();
      IREADY = 1'b1;
      n = 0;
      while (!OEN && n < 10) begin tick(); n++; end
      tests_run++;
      if (OEN !== 1'b1) begin fails++; $display("FAIL b2b_oen[%0d] got %b exp 1", it, OEN); end
      tests_run++;
      if (OHASHD_KEY !== model_key() || OHASHD_RAM !== model_vec(1) || OHASHD_SM !== model_vec(2)) begin
        fails++; $display("FAIL b2b_hash[%0d] key got %h exp %h", it, OHASHD_KEY, model_key());
      end
      tick();
      repeat ($urandom_range(5)) tick();
      sg = rnd_sign(); ISIGN = sg; IDONE = 1'b1;
      tick();
      IDONE = 1'b0;
      set_sig_model(sg);
      rd(6'h38, d);
      tests_run++;
      if (d !== 32'h2) begin fails++; $display("FAIL b2b_status[%0d] got %h exp 2", it, d); end
      k = $urandom_range(7);
      rd(6'(48+k), d);
      tests_run++;
      if (d !== ms[k]) begin fails++; $display("FAIL b2b_sig[%0d] got %h exp %h", it, d, ms[k]); end
    end
  endtask

  initial begin
    IRST = 1'b1; IWE = 1'b0; IRE = 1'b0; IADDR = '0; IWDATA = '0;
    ISTART = 1'b0; IREADY = 1'b0; IDONE = 1'b0; ISIGN = '0;
    clear_model();
    test_reset();
    test_hash_load();
    test_sign_flow();
    test_timeout();
    test_coincident();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
